// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between an ALU (A)
// and a load (B) writeback source, with a CLEAR sequencer that zeroes every register.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_READY,
  input  logic              CLEAR_REQ,
  output logic              CLEAR_BUSY,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] WRDATA,
  output logic [1:0]        GRANT
);

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              prefer_b;  // set once A has been granted, so B wins the next tie
  logic              a_ready;
  logic              b_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns both readies and no latch is inferred.
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!RESET && state == ST_ARB && !CLEAR_REQ) begin
      if (A_VALID && (!B_VALID || !prefer_b)) begin
        a_ready = 1'b1;
      end else if (B_VALID) begin
        b_ready = 1'b1;
      end
    end
  end

  assign A_READY = a_ready;
  assign B_READY = b_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_ARB;
      clr_cnt    <= '0;
      prefer_b   <= 1'b0;
      CLEAR_BUSY <= 1'b0;
      WRITE      <= 1'b0;
      INADDRESS  <= '0;
      WRDATA     <= '0;
      GRANT      <= 2'b00;
    end else begin
      case (state)
        ST_ARB: begin
          if (CLEAR_REQ) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            CLEAR_BUSY <= 1'b1;
            WRITE      <= 1'b0;
            GRANT      <= 2'b00;
          end else if (a_ready) begin
            WRITE     <= 1'b1;
            INADDRESS <= A_ADDR;
            WRDATA    <= A_DATA;
            GRANT     <= 2'b01;
            prefer_b  <= 1'b1;
          end else if (b_ready) begin
            WRITE     <= 1'b1;
            INADDRESS <= B_ADDR;
            WRDATA    <= B_DATA;
            GRANT     <= 2'b10;
            prefer_b  <= 1'b0;
          end else begin
            // Idle: address and data hold so the register file inputs stay quiet.
            WRITE <= 1'b0;
            GRANT <= 2'b00;
          end
        end
        ST_CLEAR: begin
          WRITE     <= 1'b1;
          INADDRESS <= clr_cnt;
          WRDATA    <= '0;
          GRANT     <= 2'b00;
          if (clr_cnt == LAST_REG) begin
            state      <= ST_ARB;
            clr_cnt    <= '0;
            CLEAR_BUSY <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_ARB;
          CLEAR_BUSY <= 1'b0;
          WRITE      <= 1'b0;
          GRANT      <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter: each row is one clock
// cycle of inputs, the expected combinational readies and the registered outputs after the edge.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  typedef struct {
    logic              rst;
    logic              clr;
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] bd;
    logic              exp_ar;
    logic              exp_br;
    logic              exp_w;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        exp_g;
    logic              exp_busy;
  } vec_t;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              A_VALID, B_VALID, CLEAR_REQ;
  logic [ADDR_W-1:0] A_ADDR, B_ADDR;
  logic [DATA_W-1:0] A_DATA, B_DATA;
  logic              A_READY, B_READY, CLEAR_BUSY, WRITE;
  logic [ADDR_W-1:0] INADDRESS;
  logic [DATA_W-1:0] WRDATA;
  logic [1:0]        GRANT;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
    .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(CLEAR_BUSY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .WRDATA(WRDATA), .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(
    input logic rst, input logic clr,
    input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
    input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
    input logic ar, input logic br,
    input logic w, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
    input logic [1:0] g, input logic busy);
    vec_t v;
    v.rst = rst; v.clr = clr;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.exp_ar = ar; v.exp_br = br;
    v.exp_w = w; v.exp_addr = addr; v.exp_data = data;
    v.exp_g = g; v.exp_busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, step, act, exp);
    end
  endtask

  // Drive on the falling edge, check readies mid-cycle, check registered outputs 1ns after the rise.
  task automatic run_step(input vec_t v, input int step);
    @(negedge CLK);
    RESET = v.rst; CLEAR_REQ = v.clr;
    A_VALID = v.av; A_ADDR = v.aa; A_DATA = v.ad;
    B_VALID = v.bv; B_ADDR = v.ba; B_DATA = v.bd;
    #1;
    check("ready", step, {30'd0, A_READY, B_READY}, {30'd0, v.exp_ar, v.exp_br});
    @(posedge CLK);
    #1;
    check("write", step, {31'd0, WRITE}, {31'd0, v.exp_w});
    check("inaddress", step, 32'(INADDRESS), 32'(v.exp_addr));
    check("wrdata", step, 32'(WRDATA), 32'(v.exp_data));
    check("grant", step, {30'd0, GRANT}, {30'd0, v.exp_g});
    check("clear_busy", step, {31'd0, CLEAR_BUSY}, {31'd0, v.exp_busy});
  endtask

  initial begin
    int step = 0;
    RESET = 1'b1; CLEAR_REQ = 1'b0;
    A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
    B_VALID = 1'b0; B_ADDR = '0; B_DATA = '0;

    //              rst clr av aa  ad     bv ba  bd     ar br w  addr data   g      busy
    // Reset then five idle cycles
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00, 0));
    // Single A write, then idle holds address/data
    tbl.push_back(mk(0, 0, 1, 3, 8'h2A, 0, 0, 8'h00, 1, 0, 1, 3, 8'h2A, 2'b01, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 8'h2A, 2'b00, 0));
    // Reset restores A priority, then contention alternates A,B,A,B
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00, 0));
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 1, 1, 8'h11, 2'b01, 0));
      tbl.push_back(mk(0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 1, 1, 2, 8'h22, 2'b10, 0));
    end
    // Pointer hold: A alone x3, idle x2, then tie goes to B
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 1, 4, 8'h44, 0, 0, 8'h00, 1, 0, 1, 4, 8'h44, 2'b01, 0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4, 8'h44, 2'b00, 0));
    tbl.push_back(mk(0, 0, 1, 6, 8'h66, 1, 7, 8'h77, 0, 1, 1, 7, 8'h77, 2'b10, 0));
    tbl.push_back(mk(0, 0, 1, 6, 8'h66, 0, 0, 8'h00, 1, 0, 1, 6, 8'h66, 2'b01, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 6, 8'h66, 2'b00, 0));
    // B alone
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h99, 0, 1, 1, 0, 8'h99, 2'b10, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h99, 2'b00, 0));
    // Same address from A then B: both issued in grant order, B's data last
    tbl.push_back(mk(0, 0, 1, 3, 8'h01, 1, 3, 8'h02, 1, 0, 1, 3, 8'h01, 2'b01, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 1, 3, 8'h02, 0, 1, 1, 3, 8'h02, 2'b10, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 8'h02, 2'b00, 0));

    foreach (tbl[i]) begin
      run_step(tbl[i], step);
      step++;
    end

    // CLEAR with B pending in the same cycle; B must stall until the sweep ends
    run_step(mk(0, 1, 0, 0, 8'h00, 1, 5, 8'h55, 0, 0, 0, 3, 8'h02, 2'b00, 1), step++);
    for (int k = 0; k < NREGS; k++) begin
      // A repeated CLEAR_REQ mid-sweep must not restart it
      run_step(mk(0, (k == 3), 0, 0, 8'h00, 1, 5, 8'h55, 0, 0, 1, ADDR_W'(k), 8'h00,
                  2'b00, (k != NREGS - 1)), step++);
    end
    run_step(mk(0, 0, 0, 0, 8'h00, 1, 5, 8'h55, 0, 1, 1, 5, 8'h55, 2'b10, 0), step++);
    run_step(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5, 8'h55, 2'b00, 0), step++);

    // Reset while INADDRESS=3 is presented aborts the sweep; A then gets 1-cycle latency
    run_step(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5, 8'h55, 2'b00, 1), step++);
    for (int k = 0; k < 4; k++)
      run_step(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, ADDR_W'(k), 8'h00, 2'b00, 1),
               step++);
    run_step(mk(1, 0, 1, 2, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2'b00, 0), step++);
    run_step(mk(0, 0, 1, 2, 8'h5A, 0, 0, 8'h00, 1, 0, 1, 2, 8'h5A, 2'b01, 0), step++);
    run_step(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 2, 8'h5A, 2'b00, 0), step++);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
